// File: rtl/sdram_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_cmd_arbiter
//
// Arbitrates SDRAM access between a video refill engine and a cache
// (write-back and line fill). One burst is issued at a time; the FSM walks
// IDLE -> ISSUE (command held until the controller acknowledges) -> XFER
// (data words counted) -> IDLE.
//
// Priority, sampled in IDLE only: video (vid_en & vid_low) > wb_req > fill_req.
//
// Ports
//   clk, rst            SDRAM-domain clock, synchronous active-high reset
//   vid_en, vid_low     video refill enable / FIFO almost-empty
//   frame_sync          one-cycle pulse: restart video address at 0
//   wb_req, wb_addr     cache write-back request (level) and line address
//   fill_req, fill_addr cache fill request (level) and line address
//   sys_cmd, sys_addr   command / word address to the SDRAM controller
//                       (00 nop, 01 write 256 B, 10 read 32 B, 11 read 256 B)
//   sys_cmd_ack         controller echo of the accepted command
//   sys_rd_data_valid   read word strobe, sys_dout carries the word
//   sys_wr_data_valid   write word strobe
//   vfifo_we/vfifo_data video FIFO write of a packed {second, first} word pair
//   cache_we, cache_re  cache fill / drain strobes while the cache owns XFER
//   busy                high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module sdram_cmd_arbiter #(
    parameter int VID_BURSTS  = 19200,
    parameter int VID_WORDS   = 16,
    parameter int CACHE_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vid_en,
    input  logic        vid_low,
    input  logic        frame_sync,
    input  logic        wb_req,
    input  logic [16:0] wb_addr,
    input  logic        fill_req,
    input  logic [16:0] fill_addr,
    output logic [1:0]  sys_cmd,
    output logic [22:0] sys_addr,
    input  logic [1:0]  sys_cmd_ack,
    input  logic        sys_rd_data_valid,
    input  logic        sys_wr_data_valid,
    input  logic [15:0] sys_dout,
    output logic        vfifo_we,
    output logic [31:0] vfifo_data,
    output logic        cache_we,
    output logic        cache_re,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;
    typedef enum logic {OWN_VIDEO, OWN_CACHE} owner_t;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WR256 = 2'b01;
    localparam logic [1:0] CMD_RD32  = 2'b10;
    localparam logic [1:0] CMD_RD256 = 2'b11;

    localparam int MAX_WORDS = (VID_WORDS > CACHE_WORDS) ? VID_WORDS : CACHE_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);

    localparam logic [CNT_W-1:0] VID_LAST   = CNT_W'(VID_WORDS - 1);
    localparam logic [CNT_W-1:0] CACHE_LAST = CNT_W'(CACHE_WORDS - 1);
    localparam logic [18:0]      PTR_LAST   = 19'(VID_BURSTS - 1);

    state_t            state;
    owner_t            owner;
    logic [18:0]       vid_ptr;
    logic              sync_pending;  // frame_sync seen outside IDLE, not yet applied
    logic              sync_issued;   // the video burst in ISSUE used address 0 because of sync_pending
    logic [CNT_W-1:0]  word_cnt;
    logic              pair_phase;    // 0: next video word is the low half
    logic [15:0]       held_word;

    logic              vid_eligible;
    logic              any_req;
    logic [22:0]       video_addr;
    logic [18:0]       vid_ptr_next;
    logic              xfer_video;
    logic              xfer_cache;
    logic              word_strobe;
    logic              last_word;

    assign vid_eligible = vid_en & vid_low;
    assign any_req      = vid_eligible | wb_req | fill_req;

    // A pending or same-cycle frame_sync makes the burst being issued start the frame.
    assign video_addr   = {1'b1, (frame_sync | sync_pending) ? 19'd0 : vid_ptr, 3'b000};
    assign vid_ptr_next = (vid_ptr == PTR_LAST) ? 19'd0 : vid_ptr + 19'd1;

    assign xfer_video = (state == XFER) && (owner == OWN_VIDEO);
    assign xfer_cache = (state == XFER) && (owner == OWN_CACHE);

    // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        word_strobe = 1'b0;
        if (xfer_video)
            word_strobe = sys_rd_data_valid;
        else if (xfer_cache)
            word_strobe = sys_rd_data_valid | sys_wr_data_valid;
    end

    assign last_word = (word_cnt == ((owner == OWN_VIDEO) ? VID_LAST : CACHE_LAST));

    // The cache strobes follow the controller strobes in the same cycle so the
    // cache sees each word while sys_dout / the write path are valid.
    assign cache_we = ~rst & xfer_cache & sys_rd_data_valid;
    assign cache_re = ~rst & xfer_cache & sys_wr_data_valid;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= OWN_VIDEO;
            sys_cmd      <= CMD_NOP;
            sys_addr     <= '0;
            vid_ptr      <= '0;
            sync_pending <= 1'b0;
            sync_issued  <= 1'b0;
            word_cnt     <= '0;
            pair_phase   <= 1'b0;
            held_word    <= '0;
            vfifo_we     <= 1'b0;
            vfifo_data   <= '0;
            busy         <= 1'b0;
        end else begin
            vfifo_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_sync) begin
                        vid_ptr      <= '0;
                        sync_pending <= 1'b0;
                    end
                    if (any_req) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        if (vid_eligible) begin
                            sys_cmd     <= CMD_RD32;
                            sys_addr    <= video_addr;
                            sync_issued <= sync_pending & ~frame_sync;
                        end else if (wb_req) begin
                            sys_cmd     <= CMD_WR256;
                            sys_addr    <= {wb_addr, 6'b0};
                            sync_issued <= 1'b0;
                        end else begin
                            sys_cmd     <= CMD_RD256;
                            sys_addr    <= {fill_addr, 6'b0};
                            sync_issued <= 1'b0;
                        end
                    end
                end

                ISSUE: begin
                    if (frame_sync)
                        sync_pending <= 1'b1;
                    if (sys_cmd_ack != CMD_NOP) begin
                        state      <= XFER;
                        sys_cmd    <= CMD_NOP;
                        word_cnt   <= '0;
                        pair_phase <= 1'b0;
                        // The ack value alone decides the owner; a mismatching
                        // ack of 10 still hands the transfer to video.
                        if (sys_cmd_ack == CMD_RD32) begin
                            owner <= OWN_VIDEO;
                            if (sync_issued) begin
                                // This burst already used address 0.
                                vid_ptr      <= 19'd1;
                                sync_pending <= frame_sync;
                            end else begin
                                vid_ptr <= vid_ptr_next;
                            end
                        end else begin
                            owner <= OWN_CACHE;
                        end
                    end
                end

                XFER: begin
                    if (frame_sync)
                        sync_pending <= 1'b1;
                    if (word_strobe) begin
                        if (last_word) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            word_cnt <= '0;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                    if (xfer_video && sys_rd_data_valid) begin
                        if (!pair_phase) begin
                            held_word <= sys_dout;
                        end else begin
                            vfifo_we   <= 1'b1;
                            vfifo_data <= {sys_dout, held_word};
                        end
                        pair_phase <= ~pair_phase;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_cmd_arbiter
//
// Directed bench for sdram_cmd_arbiter. The bench plays the SDRAM controller:
// it acknowledges each issued command and streams data strobes. Inputs are
// driven and outputs sampled on the falling clock edge. VID_BURSTS is reduced
// to 600 so the frame wrap is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_sdram_cmd_arbiter;

    localparam int TB_VID_BURSTS = 600;

    logic        clk;
    logic        rst;
    logic        vid_en;
    logic        vid_low;
    logic        frame_sync;
    logic        wb_req;
    logic [16:0] wb_addr;
    logic        fill_req;
    logic [16:0] fill_addr;
    logic [1:0]  sys_cmd;
    logic [22:0] sys_addr;
    logic [1:0]  sys_cmd_ack;
    logic        sys_rd_data_valid;
    logic        sys_wr_data_valid;
    logic [15:0] sys_dout;
    logic        vfifo_we;
    logic [31:0] vfifo_data;
    logic        cache_we;
    logic        cache_re;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Results gathered by the stream task.
    int          vf_pulses;
    logic [31:0] vf_first;
    logic [31:0] vf_last;
    int          cw_count;
    int          cr_count;
    logic        busy_last;
    logic        busy_after;
    logic [1:0]  cmd_after;

    sdram_cmd_arbiter #(
        .VID_BURSTS (TB_VID_BURSTS),
        .VID_WORDS  (16),
        .CACHE_WORDS(128)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .vid_en           (vid_en),
        .vid_low          (vid_low),
        .frame_sync       (frame_sync),
        .wb_req           (wb_req),
        .wb_addr          (wb_addr),
        .fill_req         (fill_req),
        .fill_addr        (fill_addr),
        .sys_cmd          (sys_cmd),
        .sys_addr         (sys_addr),
        .sys_cmd_ack      (sys_cmd_ack),
        .sys_rd_data_valid(sys_rd_data_valid),
        .sys_wr_data_valid(sys_wr_data_valid),
        .sys_dout         (sys_dout),
        .vfifo_we         (vfifo_we),
        .vfifo_data       (vfifo_data),
        .cache_we         (cache_we),
        .cache_re         (cache_re),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- helpers
    task automatic wait_cmd(output logic [1:0] cmd, output logic [22:0] addr, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (sys_cmd == 2'b00 && waited < 64);
        cmd  = sys_cmd;
        addr = sys_addr;
    endtask

    task automatic ack_cmd(input logic [1:0] a);
        sys_cmd_ack = a;
        @(negedge clk);
        sys_cmd_ack = 2'b00;
    endtask

    task automatic sample_vf();
        if (vfifo_we === 1'b1) begin
            if (vf_pulses == 0) vf_first = vfifo_data;
            vf_last = vfifo_data;
            vf_pulses++;
        end
    endtask

    // Drive n consecutive strobes (read or write); word k carries first+k.
    // frame_sync is pulsed alongside word sync_at (-1: never).
    task automatic stream(input int n, input bit wr, input logic [15:0] first, input int sync_at);
        vf_pulses = 0;
        cw_count  = 0;
        cr_count  = 0;
        busy_last = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k == n - 1) busy_last = busy;
            sys_rd_data_valid = !wr;
            sys_wr_data_valid = wr;
            sys_dout          = first + 16'(k);
            frame_sync        = (k == sync_at);
            #1;
            if (cache_we === 1'b1) cw_count++;
            if (cache_re === 1'b1) cr_count++;
            @(negedge clk);
            sample_vf();
        end
        sys_rd_data_valid = 1'b0;
        sys_wr_data_valid = 1'b0;
        frame_sync        = 1'b0;
        busy_after        = busy;
        cmd_after         = sys_cmd;
    endtask

    task automatic video_burst(input int sync_at, output logic [1:0] cmd, output logic [22:0] addr);
        int w;
        wait_cmd(cmd, addr, w);
        ack_cmd(2'b10);
        stream(16, 1'b0, 16'h0001, sync_at);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        sys_rd_data_valid = 1'b1;
        sys_wr_data_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sys_cmd !== 2'b00) begin failures++; $display("FAIL reset_cmd got=%h want=0", sys_cmd); end
        checks++; if (sys_addr !== 23'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", sys_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (vfifo_we !== 1'b0) begin failures++; $display("FAIL reset_vfifo_we got=%b want=0", vfifo_we); end
        checks++; if (vfifo_data !== 32'h0) begin failures++; $display("FAIL reset_vfifo_data got=%h want=0", vfifo_data); end
        checks++; if (cache_we !== 1'b0) begin failures++; $display("FAIL reset_cache_we got=%b want=0", cache_we); end
        checks++; if (cache_re !== 1'b0) begin failures++; $display("FAIL reset_cache_re got=%b want=0", cache_re); end
        sys_rd_data_valid = 1'b0;
        sys_wr_data_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_strobes();
        for (int k = 0; k < 3; k++) begin
            sys_rd_data_valid = 1'b1;
            sys_wr_data_valid = 1'b1;
            sys_dout          = 16'hBEEF;
            #1;
            checks++; if (cache_we !== 1'b0) begin failures++; $display("FAIL idle_cache_we got=%b want=0", cache_we); end
            checks++; if (cache_re !== 1'b0) begin failures++; $display("FAIL idle_cache_re got=%b want=0", cache_re); end
            @(negedge clk);
            checks++; if (vfifo_we !== 1'b0) begin failures++; $display("FAIL idle_vfifo_we got=%b want=0", vfifo_we); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy); end
        end
        sys_rd_data_valid = 1'b0;
        sys_wr_data_valid = 1'b0;
    endtask

    task automatic test_priority();
        logic [1:0]  c;
        logic [22:0] a;
        int          w;
        vid_en    = 1'b1;
        vid_low   = 1'b1;
        wb_req    = 1'b1;
        wb_addr   = 17'h00123;
        fill_req  = 1'b1;
        fill_addr = 17'h1ABCD;

        // Video wins.
        wait_cmd(c, a, w);
        checks++; if (c !== 2'b10) begin failures++; $display("FAIL prio_video_cmd got=%h want=2", c); end
        checks++; if (a !== 23'h400000) begin failures++; $display("FAIL prio_video_addr got=%h want=400000", a); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prio_issue_busy got=%b want=1", busy); end
        ack_cmd(2'b10);
        vid_low = 1'b0;
        stream(16, 1'b0, 16'h0001, -1);
        checks++; if (vf_pulses != 8) begin failures++; $display("FAIL video_pulses got=%0d want=8", vf_pulses); end
        checks++; if (vf_first !== 32'h00020001) begin failures++; $display("FAIL video_first got=%h want=00020001", vf_first); end
        checks++; if (vf_last !== 32'h0010000F) begin failures++; $display("FAIL video_last got=%h want=0010000f", vf_last); end
        checks++; if (cw_count != 0) begin failures++; $display("FAIL video_cache_we got=%0d want=0", cw_count); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL video_busy_end got=%b want=0", busy_after); end

        // Write-back next, after exactly one IDLE cycle.
        wait_cmd(c, a, w);
        checks++; if (w != 1) begin failures++; $display("FAIL wb_spacing got=%0d want=1", w); end
        checks++; if (c !== 2'b01) begin failures++; $display("FAIL wb_cmd got=%h want=1", c); end
        checks++; if (a !== 23'h0048C0) begin failures++; $display("FAIL wb_addr got=%h want=0048c0", a); end

        // Requests change and data strobes arrive while still in ISSUE.
        wb_addr           = 17'h1FFFF;
        wb_req            = 1'b0;
        sys_rd_data_valid = 1'b1;
        sys_wr_data_valid = 1'b1;
        #1;
        checks++; if (cache_we !== 1'b0) begin failures++; $display("FAIL issue_cache_we got=%b want=0", cache_we); end
        checks++; if (cache_re !== 1'b0) begin failures++; $display("FAIL issue_cache_re got=%b want=0", cache_re); end
        @(negedge clk);
        sys_rd_data_valid = 1'b0;
        sys_wr_data_valid = 1'b0;
        checks++; if (sys_cmd !== 2'b01) begin failures++; $display("FAIL issue_hold_cmd got=%h want=1", sys_cmd); end
        checks++; if (sys_addr !== 23'h0048C0) begin failures++; $display("FAIL issue_hold_addr got=%h want=0048c0", sys_addr); end
        ack_cmd(2'b01);
        stream(128, 1'b1, 16'h0100, -1);
        checks++; if (cr_count != 128) begin failures++; $display("FAIL wb_cache_re got=%0d want=128", cr_count); end
        checks++; if (cw_count != 0) begin failures++; $display("FAIL wb_cache_we got=%0d want=0", cw_count); end
        checks++; if (vf_pulses != 0) begin failures++; $display("FAIL wb_vfifo got=%0d want=0", vf_pulses); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL wb_busy_end got=%b want=0", busy_after); end

        // Fill last.
        wait_cmd(c, a, w);
        checks++; if (c !== 2'b11) begin failures++; $display("FAIL fill_cmd got=%h want=3", c); end
        checks++; if (a !== 23'h6AF340) begin failures++; $display("FAIL fill_addr got=%h want=6af340", a); end
        ack_cmd(2'b11);
        fill_req = 1'b0;
        stream(128, 1'b0, 16'h2000, -1);
        checks++; if (cw_count != 128) begin failures++; $display("FAIL fill_cache_we got=%0d want=128", cw_count); end
        checks++; if (cr_count != 0) begin failures++; $display("FAIL fill_cache_re got=%0d want=0", cr_count); end
        checks++; if (busy_last !== 1'b1) begin failures++; $display("FAIL fill_busy_last got=%b want=1", busy_last); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL fill_busy_end got=%b want=0", busy_after); end
        checks++; if (cmd_after !== 2'b00) begin failures++; $display("FAIL fill_cmd_end got=%h want=0", cmd_after); end
    endtask

    task automatic test_ack_mismatch();
        logic [1:0]  c;
        logic [22:0] a;
        int          w;
        fill_req  = 1'b1;
        fill_addr = 17'h00010;
        wait_cmd(c, a, w);
        checks++; if (c !== 2'b11) begin failures++; $display("FAIL mis_cmd got=%h want=3", c); end
        checks++; if (a !== 23'h000400) begin failures++; $display("FAIL mis_addr got=%h want=000400", a); end
        ack_cmd(2'b10);
        fill_req = 1'b0;
        stream(16, 1'b0, 16'hA000, -1);
        checks++; if (vf_pulses != 8) begin failures++; $display("FAIL mis_pulses got=%0d want=8", vf_pulses); end
        checks++; if (vf_first !== 32'hA001A000) begin failures++; $display("FAIL mis_first got=%h want=a001a000", vf_first); end
        checks++; if (cw_count != 0) begin failures++; $display("FAIL mis_cache_we got=%0d want=0", cw_count); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL mis_busy_end got=%b want=0", busy_after); end
    endtask

    task automatic test_frame_sync_idle();
        logic [1:0]  c;
        logic [22:0] a;
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        vid_low    = 1'b1;
        video_burst(-1, c, a);
        checks++; if ({c, a} !== {2'b10, 23'h400000}) begin failures++; $display("FAIL fs_idle_addr got=%h/%h want=2/400000", c, a); end
        video_burst(-1, c, a);
        checks++; if ({c, a} !== {2'b10, 23'h400008}) begin failures++; $display("FAIL fs_idle_next got=%h/%h want=2/400008", c, a); end
    endtask

    task automatic test_frame_sync_xfer();
        logic [1:0]  c;
        logic [22:0] a;
        logic [22:0] exp;
        for (int p = 2; p < 499; p++) begin
            exp = {1'b1, p[18:0], 3'b000};
            video_burst(-1, c, a);
            checks++; if ({c, a} !== {2'b10, exp}) begin failures++; $display("FAIL walk_addr p=%0d got=%h/%h want=2/%h", p, c, a, exp); end
        end
        // Burst 499 leaves vid_ptr at 500; frame_sync arrives during its XFER.
        video_burst(4, c, a);
        checks++; if ({c, a} !== {2'b10, 23'h400F98}) begin failures++; $display("FAIL fs_xfer_cur got=%h/%h want=2/400f98", c, a); end
        video_burst(-1, c, a);
        checks++; if ({c, a} !== {2'b10, 23'h400000}) begin failures++; $display("FAIL fs_xfer_restart got=%h/%h want=2/400000", c, a); end
        video_burst(-1, c, a);
        checks++; if ({c, a} !== {2'b10, 23'h400008}) begin failures++; $display("FAIL fs_xfer_follow got=%h/%h want=2/400008", c, a); end
    endtask

    task automatic test_wrap();
        logic [1:0]  c;
        logic [22:0] a;
        logic [22:0] exp;
        for (int p = 2; p < TB_VID_BURSTS; p++) begin
            exp = {1'b1, p[18:0], 3'b000};
            video_burst(-1, c, a);
            checks++; if ({c, a} !== {2'b10, exp}) begin failures++; $display("FAIL wrap_walk p=%0d got=%h/%h want=2/%h", p, c, a, exp); end
        end
        video_burst(-1, c, a);
        vid_low = 1'b0;
        checks++; if ({c, a} !== {2'b10, 23'h400000}) begin failures++; $display("FAIL wrap_addr got=%h/%h want=2/400000", c, a); end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  c;
        logic [22:0] a;
        int          w;
        fill_req  = 1'b1;
        fill_addr = 17'h1ABCD;
        wait_cmd(c, a, w);
        ack_cmd(2'b11);
        fill_req = 1'b0;
        stream(5, 1'b0, 16'h3000, -1);
        checks++; if (cw_count != 5) begin failures++; $display("FAIL rstmid_pre_we got=%0d want=5", cw_count); end

        rst               = 1'b1;
        sys_rd_data_valid = 1'b1;
        #1;
        checks++; if (cache_we !== 1'b0) begin failures++; $display("FAIL rstmid_we_in_rst got=%b want=0", cache_we); end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (sys_cmd !== 2'b00) begin failures++; $display("FAIL rstmid_cmd got=%h want=0", sys_cmd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (vfifo_data !== 32'h0) begin failures++; $display("FAIL rstmid_vfifo_data got=%h want=0", vfifo_data); end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (cache_we !== 1'b0) begin failures++; $display("FAIL rstmid_we k=%0d got=%b want=0", k, cache_we); end
            @(negedge clk);
            checks++; if (vfifo_we !== 1'b0) begin failures++; $display("FAIL rstmid_vfifo_we k=%0d got=%b want=0", k, vfifo_we); end
        end
        sys_rd_data_valid = 1'b0;

        // vid_ptr was cleared by the reset.
        vid_low = 1'b1;
        video_burst(-1, c, a);
        vid_low = 1'b0;
        checks++; if ({c, a} !== {2'b10, 23'h400000}) begin failures++; $display("FAIL rstmid_vid_addr got=%h/%h want=2/400000", c, a); end
    endtask

    initial begin
        rst               = 1'b1;
        vid_en            = 1'b0;
        vid_low           = 1'b0;
        frame_sync        = 1'b0;
        wb_req            = 1'b0;
        wb_addr           = '0;
        fill_req          = 1'b0;
        fill_addr         = '0;
        sys_cmd_ack       = 2'b00;
        sys_rd_data_valid = 1'b0;
        sys_wr_data_valid = 1'b0;
        sys_dout          = '0;
        @(negedge clk);

        test_reset();
        test_idle_strobes();
        test_priority();
        test_ack_mismatch();
        test_frame_sync_idle();
        test_frame_sync_xfer();
        test_wrap();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_arbiter.md
SDRAM_CMD_ARBITER -- requirements
Module: sdram_cmd_arbiter

Interface
REQ-001 Parameter VID_BURSTS, default 19200, bursts per video frame (640x480x16bpp / 32 B).
REQ-002 Parameter VID_WORDS, default 16, 16-bit words per video burst.
REQ-003 Parameter CACHE_WORDS, default 128, 16-bit words per cache burst.
REQ-004 clk  in  1  SDRAM-domain clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 vid_en  in  1  video refill enable; 0 blocks all video requests.
REQ-007 vid_low  in  1  video FIFO almost-empty; a refill is requested.
REQ-008 frame_sync  in  1  single-cycle pulse; restart the video address at 0.
REQ-009 wb_req  in  1  cache write-back request, level.
REQ-010 wb_addr  in  17  write-back line address.
REQ-011 fill_req  in  1  cache fill request, level.
REQ-012 fill_addr  in  17  fill line address.
REQ-013 sys_cmd  out  2  SDRAM command: 00 nop, 01 write 256 B, 10 read 32 B, 11 read 256 B.
REQ-014 sys_addr  out  23  SDRAM word address.
REQ-015 sys_cmd_ack  in  2  controller acknowledge, echoes the accepted command.
REQ-016 sys_rd_data_valid  in  1  read word strobe.
REQ-017 sys_wr_data_valid  in  1  write word strobe.
REQ-018 sys_dout  in  16  read data.
REQ-019 vfifo_we  out  1  video FIFO write strobe.
REQ-020 vfifo_data  out  32  packed video word {second, first}.
REQ-021 cache_we  out  1  cache fill strobe; equals sys_rd_data_valid while the owner is CACHE.
REQ-022 cache_re  out  1  cache drain strobe; equals sys_wr_data_valid while the owner is CACHE.
REQ-023 busy  out  1  high in every state except IDLE.

Function
REQ-024 FSM states are IDLE, ISSUE, XFER.
- IDLE -> ISSUE when any request is eligible.
- ISSUE -> XFER on nonzero sys_cmd_ack.
- XFER -> IDLE when the word count is reached.
REQ-025 Fixed priority, sampled in IDLE only: video (vid_en & vid_low) > wb_req > fill_req.
REQ-026 In ISSUE, sys_cmd and sys_addr are registered and held stable until ack; sys_cmd = 00 in IDLE and XFER.
REQ-027 sys_addr by command:
- video: {1'b1, vid_ptr[18:0], 3'b000}
- write-back: {wb_addr, 6'b0}
- fill: {fill_addr, 6'b0}
REQ-028 On ack, owner is latched: VIDEO for ack 10, CACHE for ack 01 or 11. An ack that differs from the issued command is treated as 10 = VIDEO, else CACHE, with no error flag.
REQ-029 vid_ptr is 19 bits and increments by 1 on each video ack; VID_BURSTS-1 wraps to 0.
REQ-030 frame_sync sets a pending flag, cleared when applied. The flag is applied at the next video ack: vid_ptr becomes 1 (the burst just issued used address 0).
REQ-031 frame_sync while IDLE resets vid_ptr to 0 immediately, without pending.
REQ-032 VIDEO XFER word pairing:
- The first valid word is held in the low half.
- The second valid word completes the pair: vfifo_we pulses 1 cycle with vfifo_data = {sys_dout, held}.
- The toggle resets at each ack.
REQ-033 XFER counts strobes: VIDEO counts sys_rd_data_valid up to VID_WORDS (8 vfifo_we pulses); CACHE counts rd or wr valid up to CACHE_WORDS; the FSM enters IDLE the cycle after the last word.
REQ-034 Data strobes in IDLE or ISSUE are ignored: no vfifo_we, cache_we or cache_re.
REQ-035 Requests that change during ISSUE do not alter the issued command.
REQ-036 Minimum spacing is 1 IDLE cycle between bursts.

Reset
REQ-037 Reset, including mid-burst, forces:
- state IDLE, sys_cmd 00, sys_addr 0
- vid_ptr 0, pending flag 0, word count 0, pair toggle 0
- vfifo_we 0, vfifo_data 0, cache_we 0, cache_re 0, busy 0
REQ-038 In-flight data strobes after reset are ignored per REQ-034.

Verification
REQ-039 vid_low=1, wb_req=1, fill_req=1 together -> sys_cmd=10, sys_addr=0x400000; after the 16 words, wb is issued (01), then fill (11).
REQ-040 Video burst with 16 words 0x0001..0x0010 -> 8 vfifo_we pulses; the first is vfifo_data=0x00020001, the last is 0x0010000F.
REQ-041 vid_ptr=19199, video ack -> next video sys_addr=0x400000.
REQ-042 fill_addr=0x1ABCD, fill burst of 128 words -> sys_addr=0x6AF340, 128 cache_we pulses, busy falls the cycle after the last word.
REQ-043 frame_sync during a video XFER with vid_ptr=500 -> next video sys_addr=0x400000, following burst 0x400008.
REQ-044 rst asserted after 5 fill words -> next cycle IDLE, sys_cmd=00; remaining valid strobes produce no cache_we.
